// File: rtl/nano2_pkg.sv
// nano2_pkg: opcode constants, phase encoding and reset opcode for the nano2 core.
package nano2_pkg;
    typedef enum logic {PH_FETCH = 1'b0, PH_EXEC = 1'b1} phase_t;
    localparam logic [7:0] OP_NOP = 8'hFF;
    localparam logic [7:0] OP_INC = 8'h00;
    localparam logic [7:0] OP_DEC = 8'h01;
    localparam logic [7:0] OP_CLR = 8'h02;
    localparam logic [7:0] OP_CPL = 8'h03;
    localparam logic [7:0] OP_SHR = 8'h04;
    localparam logic [7:0] OP_SHL = 8'h05;
    localparam logic [7:0] OP_CLE = 8'h06;
    localparam logic [7:0] OP_STE = 8'h07;
    localparam logic [7:0] OP_RTS = 8'hA0;
    localparam logic [7:0] OP_RTI = 8'hA1;
    localparam logic [7:0] OP_LDK = 8'hA2;
    // Group opcodes: high nibble, or high five bits for the skip and ADC ranges
    localparam logic [4:0] OP_SKP = 5'b00001;
    localparam logic [4:0] OP_ADC = 5'b10101;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_STK = 4'h3;
    localparam logic [3:0] OP_INA = 4'h4;
    localparam logic [3:0] OP_OTA = 4'h5;
    localparam logic [3:0] OP_SDC = 4'h6;
    localparam logic [3:0] OP_CDC = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JSB = 4'h9;
    localparam logic [3:0] OP_OTK = 4'hC;
endpackage

// File: rtl/nano2_rstack.sv
// nano2_rstack: circular return-address LIFO; a push when full drops the oldest entry,
// a pop when empty returns 0, and either sets the sticky err flag.
module nano2_rstack
    import nano2_pkg::*;
#(
    parameter int W = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         err
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW:0] cnt;
    assign full = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = empty ? '0 : mem[sp - PW'(1)];
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (push) begin
            sp <= sp + PW'(1);
            cnt <= full ? cnt : cnt + (PW+1)'(1);
            err <= err | full;
        end else if (pop) begin
            sp <= empty ? sp : sp - PW'(1);
            cnt <= empty ? cnt : cnt - (PW+1)'(1);
            err <= err | empty;
        end
    end
    always_ff @(posedge clk) if (push && !rst) mem[sp] <= din;
endmodule

// File: rtl/nano2_core.sv
// nano2_core: two-phase (FETCH/EXEC) accumulator core with hardware return stack.
// Define NANO2_ADD_EN to turn A8-AF into ADC R[i]; otherwise they are NOPs.
module nano2_core
    import nano2_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 11,
    parameter int NREG = 16,
    parameter int STK_DEPTH = 4,
    parameter int NDC = 7
) (
    input  logic           clk,
    input  logic           rst,
    output logic [AW-1:0]  PA,
    input  logic [DW-1:0]  D_in,
    output logic [DW-1:0]  D_out,
    output logic           D_oe,
    output logic           RW,
    output logic [3:0]     DS,
    output logic [NDC-1:0] DC_out,
    input  logic [NDC-1:0] DC_in,
    input  logic           INT_REQ,
    output logic           INT_ENA,
    output logic           INT_ACK,
    output logic           STK_ERR
);
    localparam int RI = $clog2(NREG);
    phase_t ph, ph_n;
    logic [7:0] instr, instr_n;
    logic [AW-1:0] pc, pc_n, pc_inc, isr, isr_n, tgt, stk_dout;
    logic [DW-1:0] acc, acc_n, r0, wd;
    logic [DW-1:0] rf [NREG];
    logic [NDC-1:0] dc, dc_n, dcm;
    logic [3:0] hi, lo;
    logic [RI-1:0] ri;
    logic e, e_n, ena, ena_n, ack, ack_n, we, push, pop, sk, stk_full, stk_empty, unused_ok;
    assign hi = instr[7:4];
    assign lo = instr[3:0];
    assign ri = instr[RI-1:0];
    assign r0 = rf[0];
    assign pc_inc = pc + AW'(1);
    assign tgt = AW'({lo, D_in[7:0]});
    assign dcm = NDC'(1) << lo;
    assign unused_ok = ^{DC_in, stk_full, stk_empty};
    assign sk = lo[2:0] == 3'd0 ? acc > r0 :
                lo[2:0] == 3'd1 ? acc < r0 :
                lo[2:0] == 3'd2 ? acc == r0 :
                lo[2:0] == 3'd3 ? acc == '0 :
                lo[2:0] == 3'd4 ? acc <= r0 :
                lo[2:0] == 3'd5 ? acc >= r0 :
                lo[2:0] == 3'd6 ? acc != r0 : acc != '0;
`ifdef NANO2_ADD_EN
    logic [RI-1:0] ai;
    assign ai = RI'(instr[2:0]);
`endif
    nano2_rstack #(.W(AW), .DEPTH(STK_DEPTH)) u_stk (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pc_inc),
        .dout(stk_dout), .full(stk_full), .empty(stk_empty), .err(STK_ERR)
    );
    always_comb begin
        ph_n = PH_FETCH;
        instr_n = instr;
        pc_n = pc;
        acc_n = acc;
        e_n = e;
        dc_n = dc;
        ena_n = ena;
        isr_n = isr;
        ack_n = 1'b0;
        we = 1'b0;
        wd = acc;
        push = 1'b0;
        pop = 1'b0;
        if (ack) begin
            isr_n = pc;
            pc_n = AW'(D_in[7:0]);
            ena_n = 1'b0;
        end else if (ph == PH_FETCH) begin
            ph_n = PH_EXEC;
            instr_n = D_in[7:0];
            pc_n = pc_inc;
        end else begin
            case (hi)
                OP_LDA: acc_n = rf[ri];
                OP_STA: we = 1'b1;
                OP_STK: begin we = 1'b1; wd = D_in; pc_n = pc_inc; end
                OP_INA: acc_n = D_in;
                OP_SDC: begin dc_n = dc | dcm; ena_n = lo == 4'd7 ? 1'b1 : ena; end
                OP_CDC: begin dc_n = dc & ~dcm; ena_n = lo == 4'd7 ? 1'b0 : ena; end
                OP_JMP: pc_n = tgt;
                OP_JSB: begin push = 1'b1; pc_n = tgt; end
                OP_OTK: pc_n = pc_inc;
                default: case (instr)
                    OP_INC: {e_n, acc_n} = {1'b0, acc} + (DW+1)'(1);
                    OP_DEC: {e_n, acc_n} = {1'b0, acc} - (DW+1)'(1);
                    OP_CLR: acc_n = '0;
                    OP_CPL: acc_n = ~acc;
                    OP_SHR: {acc_n, e_n} = {1'b0, acc};
                    OP_SHL: {e_n, acc_n} = {acc, 1'b0};
                    OP_CLE: e_n = 1'b0;
                    OP_STE: e_n = 1'b1;
                    OP_RTS: begin pop = 1'b1; pc_n = stk_dout; end
                    OP_RTI: begin pc_n = isr; ena_n = 1'b1; end
                    OP_LDK: begin acc_n = D_in; pc_n = pc_inc; end
                    default: begin
                        if (instr[7:3] == OP_SKP && sk) pc_n = pc + AW'(2);
`ifdef NANO2_ADD_EN
                        if (instr[7:3] == OP_ADC) {e_n, acc_n} = {1'b0, acc} + {1'b0, rf[ai]} + (DW+1)'(e);
`endif
                    end
                endcase
            endcase
            // Interrupt is taken on the enable state this EXEC leaves behind
            ack_n = INT_REQ && ena_n;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ph <= PH_FETCH;
            instr <= OP_NOP;
            pc <= '0;
            acc <= '0;
            e <= 1'b0;
            dc <= '1;
            ena <= 1'b0;
            ack <= 1'b0;
            isr <= '0;
        end else begin
            ph <= ph_n;
            instr <= instr_n;
            pc <= pc_n;
            acc <= acc_n;
            e <= e_n;
            dc <= dc_n;
            ena <= ena_n;
            ack <= ack_n;
            isr <= isr_n;
        end
    end
    always_ff @(posedge clk) if (we && !rst) rf[ri] <= wd;
    assign PA = pc;
    assign D_out = acc;
    assign D_oe = ph == PH_EXEC && hi == OP_OTA;
    assign RW = ph == PH_EXEC && (hi == OP_OTA || hi == OP_OTK);
    assign DS = (ph == PH_EXEC && (hi == OP_INA || hi == OP_OTA || hi == OP_OTK)) ? lo : 4'hF;
    assign DC_out = dc;
    assign INT_ENA = ena;
    assign INT_ACK = ack;
endmodule

// File: tb/tb_nano2_core.sv
// tb_nano2_core: directed programs run from a behavioural ROM with hand-computed expectations.
module tb_nano2_core;
    localparam int DW = 8, AW = 11, NDC = 7;
    logic clk = 1'b0, rst = 1'b1, INT_REQ = 1'b0;
    logic [AW-1:0] PA;
    logic [DW-1:0] D_in, D_out;
    logic D_oe, RW, INT_ENA, INT_ACK, STK_ERR;
    logic [3:0] DS;
    logic [NDC-1:0] DC_out, DC_in;
    logic [7:0] rom [0:2047];
    int n_cmp = 0, n_err = 0;
    assign DC_in = '0;
    assign D_in = rom[PA];
    always #5 clk = ~clk;
    nano2_core #(.DW(DW), .AW(AW), .NREG(16), .STK_DEPTH(4), .NDC(NDC)) dut (
        .clk(clk), .rst(rst), .PA(PA), .D_in(D_in), .D_out(D_out), .D_oe(D_oe), .RW(RW),
        .DS(DS), .DC_out(DC_out), .DC_in(DC_in), .INT_REQ(INT_REQ), .INT_ENA(INT_ENA),
        .INT_ACK(INT_ACK), .STK_ERR(STK_ERR)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask
    initial begin
        clear_rom();
        cyc(2);
        chk("rst_pa", 32'(PA), 0);
        chk("rst_acc", 32'(D_out), 0);
        chk("rst_dc", 32'(DC_out), 32'h7F);
        chk("rst_ena", 32'(INT_ENA), 0);
        chk("rst_ack", 32'(INT_ACK), 0);
        chk("rst_err", 32'(STK_ERR), 0);
        chk("rst_ds", 32'(DS), 32'hF);
        chk("rst_rw", 32'(RW), 0);
        // LDK 5A; STA R1; INC; LDA R1
        rom[0] = 8'hA2; rom[1] = 8'h5A; rom[2] = 8'h21; rom[3] = 8'h00; rom[4] = 8'h11;
        rst = 1'b0;
        cyc(7);
        chk("p1_acc", 32'(D_out), 32'h5B);
        chk("p1_pc", 32'(PA), 5);
        chk("p1_r1", 32'(dut.rf[1]), 32'h5A);
        cyc(1);
        chk("p1_lda", 32'(D_out), 32'h5A);
        // Reset during the EXEC of STA R1 must not write R1
        clear_rom();
        rom[0] = 8'hA2; rom[1] = 8'h77; rom[2] = 8'h21;
        do_reset();
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("abort_r1", 32'(dut.rf[1]), 32'h5A);
        chk("abort_acc", 32'(D_out), 0);
        chk("abort_pc", 32'(PA), 0);
        // Five nested JSBs into a 4-deep stack, then unwind
        clear_rom();
        rom[0] = 8'h91; rom[1] = 8'h10;
        rom[11'h110] = 8'h91; rom[11'h111] = 8'h20;
        rom[11'h120] = 8'h91; rom[11'h121] = 8'h30;
        rom[11'h130] = 8'h91; rom[11'h131] = 8'h40;
        rom[11'h140] = 8'h91; rom[11'h141] = 8'h50;
        rom[11'h150] = 8'hA0; rom[11'h142] = 8'hA0; rom[11'h132] = 8'hA0;
        rom[11'h122] = 8'hA0; rom[11'h112] = 8'hA0;
        do_reset();
        cyc(2);
        chk("jsb1_pc", 32'(PA), 32'h110);
        cyc(6);
        chk("jsb4_pc", 32'(PA), 32'h140);
        chk("jsb4_err", 32'(STK_ERR), 0);
        cyc(2);
        chk("jsb5_pc", 32'(PA), 32'h150);
        chk("jsb5_err", 32'(STK_ERR), 1);
        cyc(2);
        chk("rts1_pc", 32'(PA), 32'h142);
        cyc(2);
        chk("rts2_pc", 32'(PA), 32'h132);
        cyc(2);
        chk("rts3_pc", 32'(PA), 32'h122);
        cyc(2);
        chk("rts4_pc", 32'(PA), 32'h112);
        cyc(2);
        chk("rts5_pc", 32'(PA), 0);
        chk("rts5_err", 32'(STK_ERR), 1);
        // Underflow on a fresh stack
        clear_rom();
        rom[0] = 8'hA0;
        do_reset();
        chk("err_clr", 32'(STK_ERR), 0);
        cyc(2);
        chk("uflow_pc", 32'(PA), 0);
        chk("uflow_err", 32'(STK_ERR), 1);
        // Skips, INC/DEC carries, ADC
        clear_rom();
        rom[0] = 8'hA2; rom[1] = 8'h20; rom[2] = 8'h20; rom[3] = 8'hA2; rom[4] = 8'h10;
        rom[5] = 8'h09; rom[8] = 8'h08; rom[9] = 8'h0B; rom[10] = 8'h0F;
        rom[13] = 8'h02; rom[14] = 8'h01; rom[15] = 8'h00;
        rom[16] = 8'hA2; rom[17] = 8'h01; rom[18] = 8'h22; rom[19] = 8'hA2; rom[20] = 8'hFF;
        rom[21] = 8'h06; rom[22] = 8'hAA;
        do_reset();
        cyc(8);
        chk("skip_lt", 32'(PA), 8);
        cyc(2);
        chk("noskip_gt", 32'(PA), 9);
        cyc(2);
        chk("noskip_z", 32'(PA), 10);
        cyc(2);
        chk("skip_nz", 32'(PA), 13);
        cyc(4);
        chk("dec_acc", 32'(D_out), 32'hFF);
        chk("dec_e", 32'(dut.e), 1);
        cyc(2);
        chk("inc_acc", 32'(D_out), 0);
        chk("inc_e", 32'(dut.e), 1);
        cyc(8);
        chk("cle_e", 32'(dut.e), 0);
        chk("pre_adc", 32'(D_out), 32'hFF);
        cyc(2);
`ifdef NANO2_ADD_EN
        chk("adc_acc", 32'(D_out), 0);
        chk("adc_e", 32'(dut.e), 1);
`else
        chk("adc_acc", 32'(D_out), 32'hFF);
        chk("adc_e", 32'(dut.e), 0);
`endif
        chk("adc_pc", 32'(PA), 23);
        // SDC 7 with a pending request, vector 0x40, RTI, INA, CDC 5
        clear_rom();
        rom[0] = 8'h67; rom[1] = 8'h40; rom[2] = 8'h75; rom[11'h40] = 8'hA1;
        INT_REQ = 1'b1;
        do_reset();
        cyc(1);
        chk("int_pre_ack", 32'(INT_ACK), 0);
        cyc(1);
        chk("int_ack", 32'(INT_ACK), 1);
        chk("int_ena_on", 32'(INT_ENA), 1);
        chk("int_ack_pc", 32'(PA), 1);
        INT_REQ = 1'b0;
        cyc(1);
        chk("int_ack_end", 32'(INT_ACK), 0);
        chk("int_vec_pc", 32'(PA), 32'h040);
        chk("int_ena_off", 32'(INT_ENA), 0);
        chk("int_isr", 32'(dut.isr), 1);
        cyc(2);
        chk("rti_pc", 32'(PA), 1);
        chk("rti_ena", 32'(INT_ENA), 1);
        chk("rti_ack", 32'(INT_ACK), 0);
        cyc(2);
        chk("ina_acc", 32'(D_out), 32'h75);
        cyc(2);
        chk("cdc5_dc", 32'(DC_out), 32'h5F);
        // OTA dev 3 then OTK dev 7
        clear_rom();
        rom[0] = 8'hA2; rom[1] = 8'hC3; rom[2] = 8'h53; rom[3] = 8'hC7; rom[4] = 8'h99;
        do_reset();
        cyc(2);
        chk("idle_ds", 32'(DS), 32'hF);
        chk("idle_rw", 32'(RW), 0);
        chk("idle_oe", 32'(D_oe), 0);
        cyc(1);
        chk("ota_ds", 32'(DS), 3);
        chk("ota_rw", 32'(RW), 1);
        chk("ota_oe", 32'(D_oe), 1);
        chk("ota_dout", 32'(D_out), 32'hC3);
        cyc(1);
        chk("post_ds", 32'(DS), 32'hF);
        chk("post_rw", 32'(RW), 0);
        chk("post_oe", 32'(D_oe), 0);
        cyc(1);
        chk("otk_ds", 32'(DS), 7);
        chk("otk_rw", 32'(RW), 1);
        chk("otk_oe", 32'(D_oe), 0);
        cyc(1);
        chk("otk_pc", 32'(PA), 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
